// File: rtl/traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_conflict_monitor
// Purpose  : Decodes highway/country light codes into lamp drives and latches
//            a fault (flashing red on both roads) on unsafe or illegal sequences.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_conflict_monitor #(
    parameter int MIN_YELLOW  = 3,
    parameter int MIN_ALL_RED = 2,
    parameter int FLASH_HALF  = 8
) (
    input  logic       clck,
    input  logic       clear,
    input  logic [1:0] hwy,
    input  logic [1:0] cntry,
    input  logic       ack,
    output logic [2:0] hwy_lamp,
    output logic [2:0] cntry_lamp,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int c_sat_val = (MIN_YELLOW > MIN_ALL_RED) ? MIN_YELLOW : MIN_ALL_RED;
    localparam int c_cw      = $clog2(c_sat_val) + 1;
    localparam int c_fw      = $clog2(FLASH_HALF) + 1;

    localparam logic [c_cw-1:0] c_sat_cnt = c_cw'(c_sat_val);
    localparam logic [c_cw-1:0] c_min_y   = c_cw'(MIN_YELLOW);
    localparam logic [c_cw-1:0] c_min_ar  = c_cw'(MIN_ALL_RED);
    localparam logic [c_cw-1:0] c_one     = c_cw'(1);
    localparam logic [c_fw-1:0] c_flash_last = c_fw'(FLASH_HALF - 1);
    localparam logic [c_fw-1:0] c_flash_one  = c_fw'(1);

    localparam logic [1:0] c_g   = 2'b00;
    localparam logic [1:0] c_y   = 2'b10;
    localparam logic [1:0] c_r   = 2'b11;
    localparam logic [1:0] c_bad = 2'b01;

    localparam logic [2:0] c_lamp_red = 3'b100;
    localparam logic [2:0] c_lamp_off = 3'b000;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_prev_h, r_prev_c, w_prev_h, w_prev_c;
    logic [c_cw-1:0] r_dwell_h, r_dwell_c, r_allred;
    logic [c_cw-1:0] w_dwell_h, w_dwell_c, w_allred;
    logic [c_fw-1:0] r_fcnt, w_fcnt;
    logic            r_flash_on, w_flash_on;
    logic [2:0]      r_hwy_lamp, r_cntry_lamp, w_hwy_lamp, w_cntry_lamp;
    logic            r_fault, w_fault;
    logic [2:0]      r_fcode, w_fcode;

    logic            w_conflict, w_invalid, w_illegal, w_short_y, w_short_ar;
    logic [2:0]      w_chk;

    function automatic logic [2:0] decode(input logic [1:0] code);
        case (code)
            2'b00:   decode = 3'b001;
            2'b10:   decode = 3'b010;
            2'b11:   decode = 3'b100;
            default: decode = 3'b000;
        endcase
    endfunction

    function automatic logic bad_step(input logic [1:0] prev, input logic [1:0] cur);
        bad_step = ((prev == c_g) && (cur == c_r)) ||
                   ((prev == c_y) && (cur == c_g)) ||
                   ((prev == c_r) && (cur == c_y));
    endfunction

    function automatic logic [c_cw-1:0] sat_inc(input logic [c_cw-1:0] v);
        sat_inc = (v == c_sat_cnt) ? v : v + c_one;
    endfunction

    // Safety checks compare this cycle's codes against the registered history.
    always_comb begin
        w_conflict = (hwy != c_r) && (cntry != c_r);
        w_invalid  = (hwy == c_bad) || (cntry == c_bad);
        w_illegal  = bad_step(r_prev_h, hwy) || bad_step(r_prev_c, cntry);
        w_short_y  = ((r_prev_h == c_y) && (hwy == c_r) && (r_dwell_h < c_min_y)) ||
                     ((r_prev_c == c_y) && (cntry == c_r) && (r_dwell_c < c_min_y));
        w_short_ar = (((r_prev_h == c_r) && (hwy == c_g)) ||
                      ((r_prev_c == c_r) && (cntry == c_g))) && (r_allred < c_min_ar);

        if (w_conflict)      w_chk = 3'd1;
        else if (w_invalid)  w_chk = 3'd2;
        else if (w_illegal)  w_chk = 3'd3;
        else if (w_short_y)  w_chk = 3'd4;
        else if (w_short_ar) w_chk = 3'd5;
        else                 w_chk = 3'd0;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_prev_h     = r_prev_h;
        w_prev_c     = r_prev_c;
        w_dwell_h    = r_dwell_h;
        w_dwell_c    = r_dwell_c;
        w_allred     = r_allred;
        w_fcnt       = r_fcnt;
        w_flash_on   = r_flash_on;
        w_hwy_lamp   = r_hwy_lamp;
        w_cntry_lamp = r_cntry_lamp;
        w_fault      = r_fault;
        w_fcode      = r_fcode;

        case (r_state)
            ST_INIT: begin
                w_state_nxt  = ST_RUN;
                w_prev_h     = hwy;
                w_prev_c     = cntry;
                w_dwell_h    = c_sat_cnt;
                w_dwell_c    = c_sat_cnt;
                w_allred     = c_sat_cnt;
                w_hwy_lamp   = decode(hwy);
                w_cntry_lamp = decode(cntry);
            end

            ST_RUN: begin
                if (w_chk != 3'd0) begin
                    // Entry edge shows the lit half of the flash cycle.
                    w_state_nxt  = ST_FAULT;
                    w_fault      = 1'b1;
                    w_fcode      = w_chk;
                    w_fcnt       = '0;
                    w_flash_on   = 1'b1;
                    w_hwy_lamp   = c_lamp_red;
                    w_cntry_lamp = c_lamp_red;
                end else begin
                    w_prev_h     = hwy;
                    w_prev_c     = cntry;
                    w_dwell_h    = (hwy != r_prev_h) ? c_one : sat_inc(r_dwell_h);
                    w_dwell_c    = (cntry != r_prev_c) ? c_one : sat_inc(r_dwell_c);
                    w_allred     = ((hwy == c_r) && (cntry == c_r)) ? sat_inc(r_allred) : '0;
                    w_hwy_lamp   = decode(hwy);
                    w_cntry_lamp = decode(cntry);
                end
            end

            ST_FAULT: begin
                if (ack && (hwy == c_r) && (cntry == c_r)) begin
                    w_state_nxt  = ST_INIT;
                    w_fault      = 1'b0;
                    w_fcode      = 3'd0;
                    w_fcnt       = '0;
                    w_flash_on   = 1'b0;
                    w_hwy_lamp   = c_lamp_red;
                    w_cntry_lamp = c_lamp_red;
                end else begin
                    if (r_fcnt == c_flash_last) begin
                        w_fcnt     = '0;
                        w_flash_on = ~r_flash_on;
                    end else begin
                        w_fcnt     = r_fcnt + c_flash_one;
                    end
                    w_hwy_lamp   = w_flash_on ? c_lamp_red : c_lamp_off;
                    w_cntry_lamp = w_flash_on ? c_lamp_red : c_lamp_off;
                end
            end

            default: begin
                w_state_nxt  = ST_INIT;
                w_hwy_lamp   = c_lamp_red;
                w_cntry_lamp = c_lamp_red;
            end
        endcase
    end

    always_ff @(posedge clck or posedge clear) begin
        if (clear) begin
            r_state      <= ST_INIT;
            r_prev_h     <= c_r;
            r_prev_c     <= c_r;
            r_dwell_h    <= '0;
            r_dwell_c    <= '0;
            r_allred     <= '0;
            r_fcnt       <= '0;
            r_flash_on   <= 1'b0;
            r_hwy_lamp   <= c_lamp_red;
            r_cntry_lamp <= c_lamp_red;
            r_fault      <= 1'b0;
            r_fcode      <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_h     <= w_prev_h;
            r_prev_c     <= w_prev_c;
            r_dwell_h    <= w_dwell_h;
            r_dwell_c    <= w_dwell_c;
            r_allred     <= w_allred;
            r_fcnt       <= w_fcnt;
            r_flash_on   <= w_flash_on;
            r_hwy_lamp   <= w_hwy_lamp;
            r_cntry_lamp <= w_cntry_lamp;
            r_fault      <= w_fault;
            r_fcode      <= w_fcode;
        end
    end

    assign hwy_lamp   = r_hwy_lamp;
    assign cntry_lamp = r_cntry_lamp;
    assign fault      = r_fault;
    assign fault_code = r_fcode;

endmodule
`default_nettype wire

// File: tb/tb_traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_conflict_monitor
// Purpose  : Directed plus random stimulus against a history-based reference
//            model of the conflict monitor's safety rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_conflict_monitor;

    localparam int MIN_Y  = 3;
    localparam int MIN_AR = 2;
    localparam int FH     = 8;
    localparam int BIG    = 1000;

    logic       clck;
    logic       clear;
    logic [1:0] hwy, cntry;
    logic       ack;
    logic [2:0] hwy_lamp, cntry_lamp, fault_code;
    logic       fault;

    int compared   = 0;
    int mismatched = 0;

    traffic_conflict_monitor #(
        .MIN_YELLOW (MIN_Y),
        .MIN_ALL_RED(MIN_AR),
        .FLASH_HALF (FH)
    ) dut (
        .clck      (clck),
        .clear     (clear),
        .hwy       (hwy),
        .cntry     (cntry),
        .ack       (ack),
        .hwy_lamp  (hwy_lamp),
        .cntry_lamp(cntry_lamp),
        .fault     (fault),
        .fault_code(fault_code)
    );

    initial clck = 1'b0;
    always #5 clck = ~clck;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference model: history of codes since last INIT; 0=INIT 1=RUN 2=FAULT
    logic [1:0] mh[$];
    logic [1:0] mc[$];
    int         mmode;
    int         mfcyc;
    logic [2:0] e_hl, e_cl, e_code;
    logic       e_f;

    function automatic logic [2:0] lamp_of(input logic [1:0] c);
        case (c)
            2'b00:   return 3'b001;
            2'b10:   return 3'b010;
            2'b11:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit ill(input logic [1:0] p, input logic [1:0] c);
        return (p == 2'b00 && c == 2'b11) || (p == 2'b10 && c == 2'b00) ||
               (p == 2'b11 && c == 2'b10);
    endfunction

    // Length of the trailing run of the last code; reaching the INIT sample counts as saturated.
    function automatic int run_len(input logic [1:0] q[$]);
        int n = 0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i] != q[q.size() - 1]) return n;
            if (i == 0) return BIG;
            n++;
        end
        return n;
    endfunction

    function automatic int allred_len(input logic [1:0] qh[$], input logic [1:0] qc[$]);
        int n = 0;
        for (int i = qh.size() - 1; i >= 1; i--) begin
            if (qh[i] == 2'b11 && qc[i] == 2'b11) n++;
            else return n;
        end
        return BIG;
    endfunction

    task automatic model_reset();
        mh.delete();
        mc.delete();
        mmode  = 0;
        mfcyc  = 0;
        e_hl   = 3'b100;
        e_cl   = 3'b100;
        e_f    = 1'b0;
        e_code = 3'd0;
    endtask

    task automatic model_edge(input logic [1:0] h, input logic [1:0] c, input logic a);
        logic [1:0] ph, pc;
        logic [2:0] code;
        if (mmode == 0) begin
            mh.delete(); mc.delete();
            mh.push_back(h); mc.push_back(c);
            mmode = 1;
            e_hl = lamp_of(h); e_cl = lamp_of(c);
        end else if (mmode == 1) begin
            ph = mh[mh.size() - 1];
            pc = mc[mc.size() - 1];
            code = 3'd0;
            if (h != 2'b11 && c != 2'b11) code = 3'd1;
            else if (h == 2'b01 || c == 2'b01) code = 3'd2;
            else if (ill(ph, h) || ill(pc, c)) code = 3'd3;
            else if ((ph == 2'b10 && h == 2'b11 && run_len(mh) < MIN_Y) ||
                     (pc == 2'b10 && c == 2'b11 && run_len(mc) < MIN_Y)) code = 3'd4;
            else if (((ph == 2'b11 && h == 2'b00) || (pc == 2'b11 && c == 2'b00)) &&
                     allred_len(mh, mc) < MIN_AR) code = 3'd5;
            if (code != 3'd0) begin
                mmode = 2; mfcyc = 0;
                e_f = 1'b1; e_code = code;
                e_hl = 3'b100; e_cl = 3'b100;
            end else begin
                mh.push_back(h); mc.push_back(c);
                e_hl = lamp_of(h); e_cl = lamp_of(c);
            end
        end else begin
            if (a && h == 2'b11 && c == 2'b11) begin
                mmode = 0;
                e_f = 1'b0; e_code = 3'd0;
                e_hl = 3'b100; e_cl = 3'b100;
            end else begin
                mfcyc++;
                e_hl = (((mfcyc / FH) % 2) == 0) ? 3'b100 : 3'b000;
                e_cl = e_hl;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".hwy_lamp"},   hwy_lamp,   e_hl);
        chk({tag, ".cntry_lamp"}, cntry_lamp, e_cl);
        chk({tag, ".fault"},      {2'b00, fault}, {2'b00, e_f});
        chk({tag, ".fault_code"}, fault_code, e_code);
    endtask

    task automatic step(input string tag, input logic [1:0] h, input logic [1:0] c, input logic a);
        hwy = h; cntry = c; ack = a;
        @(posedge clck);
        model_edge(h, c, a);
        #1;
        check_all(tag);
    endtask

    task automatic hold(input string tag, input logic [1:0] h, input logic [1:0] c, input int n);
        for (int i = 0; i < n; i++) step(tag, h, c, 1'b0);
    endtask

    task automatic legal_cycle(input string tag);
        hold(tag, 2'b11, 2'b11, 3);
        hold(tag, 2'b00, 2'b11, 6);
        hold(tag, 2'b10, 2'b11, 3);
        hold(tag, 2'b11, 2'b11, 2);
        hold(tag, 2'b11, 2'b00, 5);
        hold(tag, 2'b11, 2'b10, 3);
        hold(tag, 2'b11, 2'b11, 2);
        hold(tag, 2'b00, 2'b11, 2);
    endtask

    task automatic do_exit(input string tag);
        step(tag, 2'b11, 2'b11, 1'b1);
        step(tag, 2'b11, 2'b11, 1'b0);
    endtask

    initial begin
        logic [1:0] rh, rc;
        clear = 1'b1; hwy = 2'b11; cntry = 2'b11; ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clck);
        #1;
        check_all("reset");
        @(negedge clck);
        clear = 1'b0;

        legal_cycle("legal");

        // Conflict, then a full flash period and a rejected acknowledge
        step("conflict", 2'b00, 2'b10, 1'b0);
        hold("flash", 2'b00, 2'b10, 20);
        step("ack_unsafe", 2'b00, 2'b00, 1'b1);
        do_exit("exit1");

        hold("sy_g", 2'b00, 2'b11, 3);
        hold("sy_y", 2'b10, 2'b11, 2);
        step("short_yellow", 2'b11, 2'b11, 1'b0);
        do_exit("exit2");
        hold("y3_g", 2'b00, 2'b11, 2);
        hold("y3_y", 2'b10, 2'b11, 3);
        hold("y3_r", 2'b11, 2'b11, 2);

        hold("gr_g", 2'b00, 2'b11, 1);
        step("g_to_r", 2'b11, 2'b11, 1'b0);
        do_exit("exit3");
        step("invalid", 2'b01, 2'b11, 1'b0);
        do_exit("exit4");
        step("conf_inv", 2'b01, 2'b00, 1'b0);
        do_exit("exit5");

        hold("ar_cg", 2'b11, 2'b00, 2);
        hold("ar_cy", 2'b11, 2'b10, 3);
        step("ar_one", 2'b11, 2'b11, 1'b0);
        step("short_allred", 2'b00, 2'b11, 1'b0);
        hold("flash2", 2'b00, 2'b11, 5);

        // Asynchronous clear in the middle of flashing
        #2;
        clear = 1'b1;
        #1;
        model_reset();
        check_all("async_clear");
        @(negedge clck);
        clear = 1'b0;
        legal_cycle("post_clear");

        rh = 2'b11; rc = 2'b11;
        for (int i = 0; i < 400; i++) begin
            if (mmode == 2 && ($urandom % 4) == 0) begin
                rh = 2'b11; rc = 2'b11;
                step("rand_exit", rh, rc, 1'b1);
            end else begin
                if (($urandom % 10) >= 7) rh = 2'($urandom);
                if (($urandom % 10) >= 7) rc = 2'($urandom);
                step("rand", rh, rc, 1'(($urandom % 4) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
